// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: D = A - B, one bit per clock, LSB first.
// Operands load in parallel on START; D/BOUT update only when a run completes.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BOUT
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sr, sr_shift;
  logic [CW-1:0]    cnt;
  logic             bw, a_bit, b_bit, d_bit, bw_next;
  logic             accept, last;

  // Full-subtractor cell fed by the registered borrow.
  always_comb begin
    a_bit   = sa[0];
    b_bit   = sb[0];
    d_bit   = a_bit ^ b_bit ^ bw;
    bw_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw);
    accept  = START && ((state == IDLE) || (state == FIN));
    last    = (cnt == CW'(WIDTH - 1));
  end

  // A 1-bit result has nothing to shift down; the new bit is the whole value.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sr_shift = d_bit;
    end else begin : g_wn
      assign sr_shift = {d_bit, sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      IDLE: begin
        if (START) state_nxt = RUN;
      end
      RUN: begin
        BUSY = 1'b1;
        if (last) state_nxt = FIN;
      end
      FIN: begin
        DONE      = 1'b1;
        state_nxt = START ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sa   <= '0;
      sb   <= '0;
      sr   <= '0;
      bw   <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      BOUT <= 1'b0;
    end else if (accept) begin
      sa  <= A;
      sb  <= B;
      sr  <= '0;
      bw  <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= sr_shift;
      bw  <= bw_next;
      cnt <= cnt + CW'(1);
      if (last) begin
        D    <= sr_shift;
        BOUT <= bw_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances) with
// an expected-result queue popped on each DONE pulse.
module tb_serial_subtractor;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;

  logic       START8 = 1'b0;
  logic [7:0] A8 = '0, B8 = '0, D8;
  logic       BUSY8, DONE8, BOUT8;

  logic       START1 = 1'b0;
  logic [0:0] A1 = '0, B1 = '0, D1;
  logic       BUSY1, DONE1, BOUT1;

  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];

  always #5 CLK = ~CLK;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .START(START8), .A(A8), .B(B8),
    .BUSY(BUSY8), .DONE(DONE8), .D(D8), .BOUT(BOUT8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(START1), .A(A1), .B(B1),
    .BUSY(BUSY1), .DONE(DONE1), .D(D1), .BOUT(BOUT1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit w1, inout int n, inout int busy);
    do begin
      @(negedge CLK);
      n++;
      busy += w1 ? int'(BUSY1) : int'(BUSY8);
    end while (!(w1 ? DONE1 : DONE8) && n < 40);
  endtask

  task automatic push8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] df;
    df = a - b;
    q8.push_back({df, (a < b)});
  endtask

  task automatic result8(input string tag, input int n, input int busy);
    logic [8:0] e;
    check({tag, "_latency"}, n, 9);
    check({tag, "_busy_cycles"}, busy, 8);
    check({tag, "_done"}, DONE8, 1);
    check({tag, "_busy_in_fin"}, BUSY8, 0);
    e = (q8.size() == 0) ? 9'bx : q8.pop_front();
    check({tag, "_d"}, D8, e[8:1]);
    check({tag, "_bout"}, BOUT8, e[0]);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input string tag);
    int n, busy;
    n = 0;
    busy = 0;
    @(negedge CLK);
    A8 = a; B8 = b; START8 = 1'b1;
    push8(a, b);
    @(posedge CLK); #1;
    START8 = 1'b0;
    A8 = ~a; B8 = ~b;
    wait_done(1'b0, n, busy);
    result8(tag, n, busy);
    @(negedge CLK);
    check({tag, "_pulse_end"}, DONE8, 0);
  endtask

  task automatic op1(input logic a, input logic b, input string tag);
    int n, busy;
    logic [1:0] e;
    n = 0;
    busy = 0;
    @(negedge CLK);
    A1 = a; B1 = b; START1 = 1'b1;
    q1.push_back({a ^ b, (!a && b)});
    @(posedge CLK); #1;
    START1 = 1'b0;
    A1 = ~a; B1 = ~b;
    wait_done(1'b1, n, busy);
    check({tag, "_latency"}, n, 2);
    check({tag, "_busy_cycles"}, busy, 1);
    check({tag, "_done"}, DONE1, 1);
    e = (q1.size() == 0) ? 2'bx : q1.pop_front();
    check({tag, "_d"}, D1, e[1]);
    check({tag, "_bout"}, BOUT1, e[0]);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, busy, dcount;

    #1 RST = 1'b1;
    #2;
    check("rst_busy8", BUSY8, 0);
    check("rst_done8", DONE8, 0);
    check("rst_d8", D8, 0);
    check("rst_bout8", BOUT8, 0);
    check("rst_busy1", BUSY1, 0);
    check("rst_done1", DONE1, 0);
    check("rst_d1", D1, 0);
    check("rst_bout1", BOUT1, 0);
    @(negedge CLK);
    RST = 1'b0;

    op8(8'h05, 8'h03, "sub_05_03");
    op8(8'h03, 8'h05, "sub_03_05");
    op8(8'h00, 8'hFF, "sub_00_ff");
    op8(8'hFF, 8'hFF, "sub_ff_ff");

    // START pulsed four cycles into a run must be ignored.
    @(negedge CLK);
    A8 = 8'h0A; B8 = 8'h04; START8 = 1'b1;
    push8(8'h0A, 8'h04);
    @(posedge CLK); #1;
    START8 = 1'b0;
    n = 0; busy = 0;
    repeat (3) begin
      @(negedge CLK); n++; busy += int'(BUSY8);
    end
    @(negedge CLK); n++; busy += int'(BUSY8);
    A8 = 8'h00; B8 = 8'h00; START8 = 1'b1;
    @(posedge CLK); #1;
    START8 = 1'b0;
    wait_done(1'b0, n, busy);
    result8("start_in_run", n, busy);
    dcount = 0;
    repeat (15) begin
      @(negedge CLK); dcount += int'(DONE8);
    end
    check("start_in_run_extra_done", dcount, 0);

    // Back-to-back with START held high; second operands appear in FIN.
    @(negedge CLK);
    A8 = 8'h80; B8 = 8'h01; START8 = 1'b1;
    push8(8'h80, 8'h01);
    @(posedge CLK); #1;
    n = 0; busy = 0;
    wait_done(1'b0, n, busy);
    result8("b2b_first", n, busy);
    A8 = 8'h10; B8 = 8'h20;
    push8(8'h10, 8'h20);
    @(posedge CLK); #1;
    START8 = 1'b0;
    check("b2b_no_idle", BUSY8, 1);
    n = 0; busy = 0;
    wait_done(1'b0, n, busy);
    result8("b2b_second", n, busy);

    // Asynchronous reset three cycles into a run.
    @(negedge CLK);
    check("hold_d_idle", D8, 8'hF0);
    check("hold_bout_idle", BOUT8, 1);
    A8 = 8'h09; B8 = 8'h02; START8 = 1'b1;
    @(posedge CLK); #1;
    START8 = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_mid_busy_before", BUSY8, 1);
    check("hold_d_in_run", D8, 8'hF0);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_busy", BUSY8, 0);
    check("rst_mid_done", DONE8, 0);
    check("rst_mid_d", D8, 0);
    check("rst_mid_bout", BOUT8, 0);
    @(negedge CLK);
    RST = 1'b0;
    dcount = 0;
    repeat (15) begin
      @(negedge CLK); dcount += int'(DONE8);
    end
    check("rst_mid_no_done", dcount, 0);
    check("rst_mid_d_after", D8, 0);

    op1(1'b0, 1'b0, "w1_0_0");
    op1(1'b0, 1'b1, "w1_0_1");
    op1(1'b1, 1'b0, "w1_1_0");
    op1(1'b1, 1'b1, "w1_1_1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor computing D = A - B, one bit per clock, LSB first.
- Built around a half-subtractor/full-subtractor cell with a registered borrow flip-flop.
- Serves as the inverse-direction companion to the team's combinational adder cells.
- Used where area matters more than latency: loads operands in parallel, iterates WIDTH cycles, presents the result in parallel with a done pulse.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- START  input  1  request pulse; sampled on CLK rising edge
- A  input  WIDTH  minuend; sampled only on the edge where START is accepted
- B  input  WIDTH  subtrahend; sampled only on the edge where START is accepted
- BUSY  output  1  high while a subtraction is in progress (RUN state)
- DONE  output  1  one-cycle pulse; D and BOUT are valid from this cycle on
- D  output  WIDTH  difference, (A - B) mod 2^WIDTH
- BOUT  output  1  final borrow; 1 iff A < B (unsigned)

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE, BUSY=0, DONE=0, D=0, BOUT=0, bit counter=0, borrow FF=0, operand shift registers=0. Reset is effective immediately, not at the next edge.
- FSM states: IDLE, RUN, FIN.
  - IDLE: START=1 moves to RUN. On the same edge: A and B are latched into shift registers, borrow FF=0, counter=0.
  - RUN: BUSY=1. Each edge:
    - a=sa[0], b=sb[0], bw=borrow FF
    - d = a^b^bw
    - next borrow = (~a&b) | (~(a^b)&bw)
    - d shifts into the MSB of the result shift register
    - sa and sb shift right by one
    - counter increments
  - RUN exit: on the edge where counter==WIDTH-1 (WIDTH bits processed), go to FIN. On that same edge, load the D register from the completed shift value and load BOUT from the next borrow.
  - FIN: DONE=1, BUSY=0 for exactly one cycle.
    - START=1 in FIN is accepted exactly as in IDLE: new operands latched, go to RUN.
    - Otherwise go to IDLE.
- Latency: if START is accepted at edge k, DONE is high in the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles with back-to-back START.
- D and BOUT change only on the completion edge. They hold their value through IDLE and through a later RUN until that run completes. The partial shift value is never visible on D.
- START while in RUN is ignored. Operands are not resampled and the run is not restarted.
- A and B may change freely after the accept edge; the result depends only on the latched values.
- WIDTH=1: RUN lasts exactly one edge. The counter compare must still hold (counter width = max(1, clog2(WIDTH))).
- Reset mid-RUN: the run is abandoned with no DONE pulse. D and BOUT return to 0.
- Arithmetic: all unsigned; no overflow flag other than BOUT.

Test Plan:
- WIDTH=8, reset then START with A=0x05, B=0x03:
  - BUSY high for 8 cycles
  - DONE one cycle, 9 cycles after the accept edge
  - D=0x02, BOUT=0
- WIDTH=8, A=0x03, B=0x05 → D=0xFE, BOUT=1. Then A=0x00, B=0xFF → D=0x01, BOUT=1. Then A=0xFF, B=0xFF → D=0x00, BOUT=0.
- Back-to-back operations:
  - START held high continuously with A=0x80, B=0x01, then A=0x10, B=0x20 presented at the FIN cycle
  - Required: DONE pulses with D=0x7F/BOUT=0, then D=0xF0/BOUT=1, 9 cycles apart, with no IDLE cycle between runs.
- START during RUN:
  - Pulse START with A=0x00, B=0x00 four cycles into a run of A=0x0A, B=0x04
  - Required: the run is unaffected, D=0x06, BOUT=0, only one DONE pulse.
- Reset mid-run:
  - Assert RST asynchronously (between edges) three cycles into a run of A=0x09, B=0x02
  - Required: BUSY, DONE, D and BOUT drop to 0 before the next edge; no DONE pulse after RST is released.
- WIDTH=1 instance, all four (A,B) combos:
  - (0,0)→D=0,BOUT=0; (0,1)→D=1,BOUT=1; (1,0)→D=1,BOUT=0; (1,1)→D=0,BOUT=0
  - DONE 2 cycles after the accept edge.
